// File: rtl/kmeans_centroid_update_k2n2.sv
// Two-centroid, two-dimension k-means update: reads each centroid's accumulated sums and count,
// divides them with a pair of bit-serial restoring dividers and reports whether the centroids moved.
module kmeans_centroid_update_k2n2 #(
  parameter int input_data_width         = 8,
  parameter int input_data_qty_bit_width = 8,
  parameter int acc_width                = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [input_data_width-1:0]         k0d0,
  input  logic [input_data_width-1:0]         k0d1,
  input  logic [input_data_width-1:0]         k1d0,
  input  logic [input_data_width-1:0]         k1d1,
  output logic                                rd_acc_en,
  output logic                                rd_acc_centroid,
  input  logic [acc_width-1:0]                acc0_in,
  input  logic [acc_width-1:0]                acc1_in,
  input  logic [input_data_qty_bit_width-1:0] acc_counter_in,
  output logic [input_data_width-1:0]         new_k0d0,
  output logic [input_data_width-1:0]         new_k0d1,
  output logic [input_data_width-1:0]         new_k1d0,
  output logic [input_data_width-1:0]         new_k1d1,
  output logic                                busy,
  output logic                                done,
  output logic                                converged
);

  localparam int iw    = input_data_width;
  localparam int qw    = input_data_qty_bit_width;
  localparam int aw    = acc_width;
  localparam int cnt_w = $clog2(aw + 1);
  localparam logic [aw-1:0] max_q = {{(aw - iw){1'b0}}, {iw{1'b1}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DIV   = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic              c_r;
  logic [iw-1:0]     sh_k0d0_r, sh_k0d1_r, sh_k1d0_r, sh_k1d1_r;
  logic [aw-1:0]     q0_r, q1_r;
  logic [qw-1:0]     rem0_r, rem1_r;
  logic [qw-1:0]     den_r;
  logic [cnt_w-1:0]  bit_cnt_r;
  logic [qw:0]       trial0_s, trial1_s;
  logic              ge0_s, ge1_s;
  logic [iw-1:0]     wr_d0_s, wr_d1_s;
  logic              conv_s;

  function automatic logic [iw-1:0] sat_q(input logic [aw-1:0] q);
    logic [iw-1:0] r;
    if (q > max_q) begin
      r = {iw{1'b1}};
    end else begin
      r = q[iw-1:0];
    end
    return r;
  endfunction

  // One restoring-division step: the dividend shifts out of q_r MSB first while quotient bits shift in.
  always_comb begin
    trial0_s = {rem0_r, q0_r[aw-1]};
    trial1_s = {rem1_r, q1_r[aw-1]};
    ge0_s    = (trial0_s >= {1'b0, den_r});
    ge1_s    = (trial1_s >= {1'b0, den_r});
  end

  // Values written in STORE; an empty cluster keeps its old position.
  always_comb begin
    wr_d0_s = {iw{1'b0}};
    wr_d1_s = {iw{1'b0}};
    if (den_r == {qw{1'b0}}) begin
      wr_d0_s = c_r ? sh_k1d0_r : sh_k0d0_r;
      wr_d1_s = c_r ? sh_k1d1_r : sh_k0d1_r;
    end else begin
      wr_d0_s = sat_q(q0_r);
      wr_d1_s = sat_q(q1_r);
    end
    conv_s = (new_k0d0 == sh_k0d0_r) && (new_k0d1 == sh_k0d1_r) &&
             (wr_d0_s == sh_k1d0_r) && (wr_d1_s == sh_k1d1_r);
  end

  // Control FSM, dividers, shadow registers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      c_r             <= 1'b0;
      sh_k0d0_r       <= {iw{1'b0}};
      sh_k0d1_r       <= {iw{1'b0}};
      sh_k1d0_r       <= {iw{1'b0}};
      sh_k1d1_r       <= {iw{1'b0}};
      q0_r            <= {aw{1'b0}};
      q1_r            <= {aw{1'b0}};
      rem0_r          <= {qw{1'b0}};
      rem1_r          <= {qw{1'b0}};
      den_r           <= {qw{1'b0}};
      bit_cnt_r       <= {cnt_w{1'b0}};
      rd_acc_en       <= 1'b0;
      rd_acc_centroid <= 1'b0;
      new_k0d0        <= {iw{1'b0}};
      new_k0d1        <= {iw{1'b0}};
      new_k1d0        <= {iw{1'b0}};
      new_k1d1        <= {iw{1'b0}};
      busy            <= 1'b0;
      done            <= 1'b0;
      converged       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_k0d0_r       <= k0d0;
            sh_k0d1_r       <= k0d1;
            sh_k1d0_r       <= k1d0;
            sh_k1d1_r       <= k1d1;
            c_r             <= 1'b0;
            converged       <= 1'b0;
            busy            <= 1'b1;
            rd_acc_en       <= 1'b1;
            rd_acc_centroid <= 1'b0;
            state_r         <= READ;
          end else begin
            busy      <= 1'b0;
            rd_acc_en <= 1'b0;
          end
        end
        READ: begin
          rd_acc_en <= 1'b0;
          q0_r      <= acc0_in;
          q1_r      <= acc1_in;
          den_r     <= acc_counter_in;
          rem0_r    <= {qw{1'b0}};
          rem1_r    <= {qw{1'b0}};
          bit_cnt_r <= {cnt_w{1'b0}};
          state_r   <= DIV;
        end
        DIV: begin
          rem0_r    <= ge0_s ? qw'(trial0_s - {1'b0, den_r}) : qw'(trial0_s);
          rem1_r    <= ge1_s ? qw'(trial1_s - {1'b0, den_r}) : qw'(trial1_s);
          q0_r      <= {q0_r[aw-2:0], ge0_s};
          q1_r      <= {q1_r[aw-2:0], ge1_s};
          bit_cnt_r <= bit_cnt_r + cnt_w'(1);
          if (bit_cnt_r == cnt_w'(aw - 1)) begin
            state_r <= STORE;
          end
        end
        STORE: begin
          if (!c_r) begin
            new_k0d0        <= wr_d0_s;
            new_k0d1        <= wr_d1_s;
            c_r             <= 1'b1;
            rd_acc_en       <= 1'b1;
            rd_acc_centroid <= 1'b1;
            state_r         <= READ;
          end else begin
            new_k1d0  <= wr_d0_s;
            new_k1d1  <= wr_d1_s;
            done      <= 1'b1;
            converged <= conv_s;
            state_r   <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          rd_acc_en <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_centroid_update_k2n2.sv
// Bench for kmeans_centroid_update_k2n2: directed and random runs against an arithmetic reference model.
module tb_kmeans_centroid_update_k2n2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  k0d0, k0d1, k1d0, k1d1;
  logic        rd_acc_en, rd_acc_centroid;
  logic [15:0] acc0_in, acc1_in;
  logic [7:0]  acc_counter_in;
  logic [7:0]  new_k0d0, new_k0d1, new_k1d0, new_k1d1;
  logic        busy, done, converged;

  logic [15:0] line_a0 [2];
  logic [15:0] line_a1 [2];
  logic [7:0]  line_cnt [2];
  logic [7:0]  old_k [4];
  logic [7:0]  mdl_k [4];
  int          n_cmp = 0;
  int          n_err = 0;

  kmeans_centroid_update_k2n2 dut (
    .clk(clk), .rst(rst), .start(start),
    .k0d0(k0d0), .k0d1(k0d1), .k1d0(k1d0), .k1d1(k1d1),
    .rd_acc_en(rd_acc_en), .rd_acc_centroid(rd_acc_centroid),
    .acc0_in(acc0_in), .acc1_in(acc1_in), .acc_counter_in(acc_counter_in),
    .new_k0d0(new_k0d0), .new_k0d1(new_k0d1), .new_k1d0(new_k1d0), .new_k1d1(new_k1d1),
    .busy(busy), .done(done), .converged(converged)
  );

  always #5 clk = ~clk;

  // Accumulator memory answers combinationally for the line being read.
  assign acc0_in        = line_a0[rd_acc_centroid];
  assign acc1_in        = line_a1[rd_acc_centroid];
  assign acc_counter_in = line_cnt[rd_acc_centroid];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mdl_coord(input int unsigned sum, input int unsigned cnt,
                                           input logic [7:0] old);
    int unsigned q;
    if (cnt == 0) return old;
    q = sum / cnt;
    if (q > 255) return 8'hFF;
    return q[7:0];
  endfunction

  task automatic set_case(input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2,
                          input logic [7:0] o3, input logic [15:0] a00, input logic [15:0] a10,
                          input logic [7:0] c0, input logic [15:0] a01, input logic [15:0] a11,
                          input logic [7:0] c1);
    old_k[0] = o0; old_k[1] = o1; old_k[2] = o2; old_k[3] = o3;
    line_a0[0] = a00; line_a1[0] = a10; line_cnt[0] = c0;
    line_a0[1] = a01; line_a1[1] = a11; line_cnt[1] = c1;
  endtask

  // Start sampled at edge 0: done must rise on edge 36, i.e. be high in cycle T+37 only.
  task automatic run_case(input bit poke);
    logic [7:0] exp_k [4];
    logic       exp_conv;
    int         done_cnt, done_at, rd_cnt;
    exp_k[0] = mdl_coord(line_a0[0], line_cnt[0], old_k[0]);
    exp_k[1] = mdl_coord(line_a1[0], line_cnt[0], old_k[1]);
    exp_k[2] = mdl_coord(line_a0[1], line_cnt[1], old_k[2]);
    exp_k[3] = mdl_coord(line_a1[1], line_cnt[1], old_k[3]);
    exp_conv = (exp_k[0] == old_k[0]) && (exp_k[1] == old_k[1]) &&
               (exp_k[2] == old_k[2]) && (exp_k[3] == old_k[3]);
    @(negedge clk);
    k0d0 = old_k[0]; k0d1 = old_k[1]; k1d0 = old_k[2]; k1d1 = old_k[3];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k0d0 = 8'($urandom); k0d1 = 8'($urandom); k1d0 = 8'($urandom); k1d1 = 8'($urandom);
    check_val("rd_en_first", rd_acc_en, 1);
    check_val("rd_c_first", rd_acc_centroid, 0);
    check_val("busy_start", busy, 1);
    check_val("conv_cleared", converged, 0);
    done_cnt = 0; done_at = -1; rd_cnt = 1;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      start = (poke && n == 4);
      if (rd_acc_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == 5) check_val("busy_div", busy, 1);
      if (n == 18) begin
        check_val("rd_en_second", rd_acc_en, 1);
        check_val("rd_c_second", rd_acc_centroid, 1);
      end
      if (n == 19) begin
        check_val("k0d0_early", new_k0d0, exp_k[0]);
        check_val("k0d1_early", new_k0d1, exp_k[1]);
        check_val("k1d0_held", new_k1d0, mdl_k[2]);
        check_val("k1d1_held", new_k1d1, mdl_k[3]);
      end
      if (n == 36) begin
        check_val("k0d0", new_k0d0, exp_k[0]);
        check_val("k0d1", new_k0d1, exp_k[1]);
        check_val("k1d0", new_k1d0, exp_k[2]);
        check_val("k1d1", new_k1d1, exp_k[3]);
        check_val("conv_done", converged, exp_conv);
      end
      if (n == 45) begin
        check_val("conv_held", converged, exp_conv);
        check_val("busy_idle", busy, 0);
        check_val("k1d1_hold", new_k1d1, exp_k[3]);
      end
    end
    check_val("done_latency", done_at, 36);
    check_val("done_count", done_cnt, 1);
    check_val("rd_cycles", rd_cnt, 2);
    for (int i = 0; i < 4; i++) mdl_k[i] = exp_k[i];
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_conv"}, converged, 0);
    check_val({tag, "_rd"}, {rd_acc_en, rd_acc_centroid}, 0);
    check_val({tag, "_k"}, {new_k0d0, new_k0d1, new_k1d0, new_k1d1}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    k0d0 = 8'd0; k0d1 = 8'd0; k1d0 = 8'd0; k1d1 = 8'd0;
    for (int i = 0; i < 4; i++) mdl_k[i] = 8'd0;
    set_case(8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 8'd0, 16'd0, 16'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    set_case(8'd0, 8'd0, 8'd1, 8'd1, 16'd100, 16'd60, 8'd10, 16'd250, 16'd50, 8'd5);
    run_case(1'b0);
    set_case(8'd0, 8'd0, 8'd7, 8'd9, 16'd100, 16'd60, 8'd10, 16'd250, 16'd50, 8'd0);
    run_case(1'b0);
    set_case(8'd10, 8'd6, 8'd50, 8'd10, 16'd100, 16'd60, 8'd10, 16'd250, 16'd50, 8'd5);
    run_case(1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_val("conv_idle_hold", converged, 1);
    set_case(8'd0, 8'd0, 8'd0, 8'd0, 16'd7, 16'hFFFF, 8'd2, 16'hFFFF, 16'd1, 8'd1);
    run_case(1'b0);
    set_case(8'd3, 8'd4, 8'd5, 8'd6, 16'd100, 16'd60, 8'd10, 16'd250, 16'd50, 8'd5);
    run_case(1'b1);

    // Reset in the middle of the first division: outputs clear without a clock edge.
    set_case(8'd0, 8'd0, 8'd1, 8'd1, 16'd100, 16'd60, 8'd10, 16'd250, 16'd50, 8'd5);
    @(negedge clk);
    k0d0 = old_k[0]; k0d1 = old_k[1]; k1d0 = old_k[2]; k1d1 = old_k[3];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    check_val("midrst_nodone", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl_k[i] = 8'd0;
    run_case(1'b0);

    for (int it = 0; it < 6; it++) begin
      int r0, r1;
      r0 = $urandom_range(0, 3);
      r1 = $urandom_range(0, 3);
      set_case(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               16'($urandom), 16'($urandom),
               (r0 == 0) ? 8'd0 : (r0 == 1) ? 8'($urandom_range(1, 8)) : 8'($urandom_range(1, 255)),
               16'($urandom), 16'($urandom),
               (r1 == 0) ? 8'd0 : (r1 == 1) ? 8'($urandom_range(1, 8)) : 8'($urandom_range(1, 255)));
      run_case(it == 3);
      for (int i = 0; i < 4; i++) old_k[i] = mdl_k[i];
      run_case(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
